// File: rtl/fetch_stage.sv
// Instruction fetch: pc generation, IF/ID output register and a one-entry skid buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets in a FAULT state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN, FAULT} state_t;
`else
  typedef enum logic {RUN} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        or_valid_q, or_valid_d;
  logic [31:0] or_instr_q, or_instr_d;
  logic [31:0] or_pc_q, or_pc_d;
  logic        sk_valid_q, sk_valid_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic [31:0] sk_pc_q, sk_pc_d;

  logic resp;
  logic show_resp;
  logic consumed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      or_valid_q <= 1'b0;
      or_instr_q <= '0;
      or_pc_q    <= '0;
      sk_valid_q <= 1'b0;
      sk_instr_q <= '0;
      sk_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      or_valid_q <= or_valid_d;
      or_instr_q <= or_instr_d;
      or_pc_q    <= or_pc_d;
      sk_valid_q <= sk_valid_d;
      sk_instr_q <= sk_instr_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    infl_d     = 1'b0;
    infl_pc_d  = infl_pc_q;
    or_valid_d = or_valid_q;
    or_instr_d = or_instr_q;
    or_pc_d    = or_pc_q;
    sk_valid_d = sk_valid_q;
    sk_instr_d = sk_instr_q;
    sk_pc_d    = sk_pc_q;

    // A fresh response is shown to decode straight from memory when OR is empty,
    // giving one cycle from request to id_valid; it is only registered if decode stalls.
    resp        = infl_q & ~redirect_valid & ~reset;
    show_resp   = resp & ~or_valid_q;
    id_valid    = ~reset & (or_valid_q | show_resp);
    id_instr    = reset ? '0 : (show_resp ? imem_rdata : or_instr_q);
    id_pc       = reset ? '0 : (show_resp ? infl_pc_q : or_pc_q);
    id_pc_plus4 = id_pc + 32'd4;
    consumed    = id_valid & id_ready;

    imem_addr = pc_q;
    imem_req  = ~reset & (state_q == RUN) & ~redirect_valid & ~sk_valid_q
              & ~(or_valid_q & ~id_ready & resp);

    if (imem_req) begin
      infl_d    = 1'b1;
      infl_pc_d = pc_q;
      pc_d      = pc_q + 32'd4;
    end

    if (redirect_valid) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
      infl_d     = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d    = redirect_pc;
      state_d = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`else
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else if (or_valid_q) begin
      if (consumed) begin
        if (sk_valid_q) begin
          or_instr_d = sk_instr_q;
          or_pc_d    = sk_pc_q;
          sk_valid_d = resp;
          sk_instr_d = imem_rdata;
          sk_pc_d    = infl_pc_q;
        end else if (resp) begin
          or_instr_d = imem_rdata;
          or_pc_d    = infl_pc_q;
        end else begin
          or_valid_d = 1'b0;
        end
      end else if (resp) begin
        sk_valid_d = 1'b1;
        sk_instr_d = imem_rdata;
        sk_pc_d    = infl_pc_q;
      end
    end else if (resp && !id_ready) begin
      or_valid_d = 1'b1;
      or_instr_d = imem_rdata;
      or_pc_d    = infl_pc_q;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = ~reset & (state_q == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected pc stream is generated from the program-order
// rules (sequential +4, restart at redirect/reset target) and checked at every handshake.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, imem_req, redirect_valid, id_valid, id_ready, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc, id_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault)
  );

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_pc       = RESET_PC;
  logic        pending_flush  = 1'b1;
  logic [31:0] pending_target = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  // Instruction memory: word valid one cycle after the request, garbage otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; the reference stream reacts to redirect/reset at the
  // following edge so a handshake coinciding with the flush still belongs to the old stream.
  task automatic tick(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    if (pending_flush) begin
      exp_q.delete();
      model_pc = pending_target;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    #1;
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    pending_flush  = r | rv;
    pending_target = r ? RESET_PC : (rpc & 32'hFFFF_FFFC);
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    tick(r, rv, rpc, rdy);
    @(negedge clk);
  endtask

  // Monitor: every accepted instruction must be the next one in program order.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset === 1'b1) begin
      check1("reset_id_valid", id_valid, 1'b0);
    end else if (id_valid === 1'b1 && id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got pc %h expected none", id_pc);
      end else begin
        e = exp_q.pop_front();
        delivered++;
        $display("xfer pc=%h instr=%h pc4=%h", id_pc, id_instr, id_pc_plus4);
        check("id_pc", id_pc, e);
        check("id_instr", id_instr, mem_word(e));
        check("id_pc_plus4", id_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    int cnt;
    int start;
    logic [31:0] rpc;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    check1("rst_imem_req", imem_req, 1'b0);
    check1("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check1("rst_fault", fetch_fault, 1'b0);
    check("rst_pc", imem_addr, RESET_PC);

    // Reset release: first fetch immediately, data one cycle later
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check1("rel_req", imem_req, 1'b1);
    check("rel_addr0", imem_addr, RESET_PC);
    check1("rel_no_valid", id_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rel_addr1", imem_addr, RESET_PC + 32'd4);
    check1("rel_valid1", id_valid, 1'b1);
    check("rel_id_pc0", id_pc, RESET_PC);
    check("rel_pc4_0", id_pc_plus4, RESET_PC + 32'd4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rel_addr2", imem_addr, RESET_PC + 32'd8);
    check("rel_id_pc1", id_pc, RESET_PC + 32'd4);

    // Throughput: one instruction per cycle
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (id_valid === 1'b1) cnt++;
    end
    check("throughput", cnt, 8);

    // Five-cycle decode stall, then release with no gaps
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      if (i >= 2) begin
        check1("stall_req_low", imem_req, 1'b0);
        check1("stall_valid", id_valid, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check1("resume_valid", id_valid, 1'b1);
    end

    // Redirect with OR and SK full
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    check1("full_valid", id_valid, 1'b1);
    check1("full_req_low", imem_req, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    check1("redir_req_low", imem_req, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_addr", imem_addr, 32'h100);
    check1("redir_req", imem_req, 1'b1);
    check1("redir_flushed", id_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check1("redir_valid", id_valid, 1'b1);
    check("redir_id_pc", id_pc, 32'h100);

    // Misaligned redirect target
    step(1'b0, 1'b1, 32'h102, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("mis_fault", fetch_fault, 1'b1);
    check1("mis_req_low", imem_req, 1'b0);
    check1("mis_valid_low", id_valid, 1'b0);
`else
    check("mis_addr", imem_addr, 32'h100);
    check1("mis_req", imem_req, 1'b1);
    check1("mis_no_fault", fetch_fault, 1'b0);
`endif
    step(1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("align_addr", imem_addr, 32'h200);
    check1("align_req", imem_req, 1'b1);
    check1("align_no_fault", fetch_fault, 1'b0);

    // Address wrap at the top of memory
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_addr2", imem_addr, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc_plus4, 32'h0);

    // Randomized traffic
    start = delivered;
    for (int i = 0; i < 300; i++) begin
      rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc = rpc & 32'hFFFF_FFFC;
`endif
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), rpc,
           ($urandom_range(0, 3) != 0));
    end
    check1("random_progress", (delivered - start) > 100, 1'b1);

    // Reset during a full stall
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    check1("pre_rst_valid", id_valid, 1'b1);
    check1("pre_rst_req", imem_req, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check1("mid_rst_valid", id_valid, 1'b0);
    check1("mid_rst_req", imem_req, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check1("post_rst_valid", id_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check1("rerel_req", imem_req, 1'b1);
    check("rerel_addr", imem_addr, RESET_PC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check1("rerel_valid", id_valid, 1'b1);
    check("rerel_id_pc", id_pc, RESET_PC);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
